// File: rtl/wchb_sync_bridge.sv
// wchb_sync_bridge
// Bridges a 4-phase bundled-data asynchronous channel into a clocked
// valid/ready stream through a DEPTH-entry token FIFO. The incoming request
// is synchronised; the acknowledge is a registered output.
// Optional feature macro: WCHB_BRIDGE_COUNT_EN adds a 16-bit write counter
// output o_xfer_cnt. Without the macro the port and its logic are absent.
module wchb_sync_bridge #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_req,
    input  logic [WIDTH-1:0]           i_data,
    output logic                       o_ack,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_level
`ifdef WCHB_BRIDGE_COUNT_EN
    ,
    output logic [15:0]                o_xfer_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(DEPTH + 1);

    typedef enum logic {
        IDLE,
        ACK_HIGH
    } state_t;

    state_t                 state_q, state_d;
    logic                   ack_q, ack_d;
    logic [SYNC_STAGES-1:0] reqSync_q;
    logic                   reqS;
    logic [PW-1:0]          wrPtr_q, wrPtr_d;
    logic [PW-1:0]          rdPtr_q, rdPtr_d;
    logic [PW-1:0]          levelRaw;
    logic [WIDTH-1:0]       mem [DEPTH];
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   empty;

    assign reqS  = reqSync_q[SYNC_STAGES-1];
    assign full  = (wrPtr_q[PW-1] != rdPtr_q[PW-1]) &&
                   (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign empty = (wrPtr_q == rdPtr_q);
    assign pop   = !empty && i_ready;

    // Shift the asynchronous request through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reqSync_q <= '0;
        end else begin
            reqSync_q <= {reqSync_q[SYNC_STAGES-2:0], i_req};
        end
    end

    // Handshake FSM: accept a token when the buffer has room, then wait for request release.
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (reqS && !full) begin
                    push    = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ACK_HIGH;
                end
            end
            ACK_HIGH: begin
                if (!reqS) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Next pointer values; full is judged on the pre-edge pointers so a same-edge pop cannot admit a push.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (push) begin
            wrPtr_d = wrPtr_q + {{(PW-1){1'b0}}, 1'b1};
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + {{(PW-1){1'b0}}, 1'b1};
        end
    end

    // Control state, acknowledge and FIFO pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    // Token storage; i_data is sampled directly because req_s high guarantees it has settled.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr_q[AW-1:0]] <= i_data;
        end
    end

`ifdef WCHB_BRIDGE_COUNT_EN
    logic [15:0] xferCnt_q;

    // Count every FIFO write, wrapping naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xferCnt_q <= '0;
        end else if (push) begin
            xferCnt_q <= xferCnt_q + 16'd1;
        end
    end

    assign o_xfer_cnt = xferCnt_q;
`endif

    assign levelRaw = wrPtr_q - rdPtr_q;
    assign o_level  = LW'(levelRaw);
    assign o_ack    = ack_q;
    assign o_valid  = !empty;
    assign o_data   = empty ? '0 : mem[rdPtr_q[AW-1:0]];

endmodule
